// File: rtl/s_axi_lite_regfile_pkg.sv
// Shared response codes and address helpers for the AXI4-Lite register file.
package s_axi_lite_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address to word index; the two low address bits are dropped.
  function automatic int unsigned word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/s_axi_lite_regfile_wstrb.sv
// Byte-enable merge of new write data into an existing register word.
module axi_lite_wstrb_merge #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0]   old_i,
  input  logic [DWIDTH-1:0]   wdata_i,
  input  logic [DWIDTH/8-1:0] wstrb_i,
  output logic [DWIDTH-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DWIDTH / 8; b++) begin
      if (wstrb_i[b]) merged_o[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/s_axi_lite_regfile.sv
// AXI4-Lite slave register file: single-beat writes/reads, SLVERR outside NUM_REG,
// register 0 exported as ctrl.
module s_axi_lite_regfile
  import s_axi_lite_regfile_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int REG_WIDTH = 6,
  parameter int NUM_REG   = 8
) (
  input  logic                 clk_i,
  input  logic                 xrst_i,
  input  logic                 awvalid_i,
  input  logic [REG_WIDTH-1:0] awaddr_i,
  input  logic [2:0]           awprot_i,
  output logic                 awready_o,
  input  logic                 wvalid_i,
  input  logic [DWIDTH-1:0]    wdata_i,
  input  logic [DWIDTH/8-1:0]  wstrb_i,
  output logic                 wready_o,
  output logic                 bvalid_o,
  output logic [1:0]           bresp_o,
  input  logic                 bready_i,
  input  logic                 arvalid_i,
  input  logic [REG_WIDTH-1:0] araddr_i,
  input  logic [2:0]           arprot_i,
  output logic                 arready_o,
  output logic [DWIDTH-1:0]    rdata_o,
  output logic [1:0]           rresp_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DWIDTH-1:0]    ctrl_o
);

  localparam int SW = DWIDTH / 8;

  logic                 awready_q, awready_d;
  logic                 aw_held_q, aw_held_d;
  logic [REG_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic                 wready_q,  wready_d;
  logic                 w_held_q,  w_held_d;
  logic [DWIDTH-1:0]    wdata_q,   wdata_d;
  logic [SW-1:0]        wstrb_q,   wstrb_d;
  logic                 bvalid_q,  bvalid_d;
  logic [1:0]           bresp_q,   bresp_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q,  rvalid_d;
  logic [DWIDTH-1:0]    rdata_q,   rdata_d;
  logic [1:0]           rresp_q,   rresp_d;
  logic [DWIDTH-1:0]    regs_q [NUM_REG];
  logic [DWIDTH-1:0]    regs_d [NUM_REG];

  logic                 aw_hs, w_hs, ar_hs, commit;
  int unsigned          wr_idx, rd_idx;
  logic                 wr_in_range, rd_in_range;
  logic [DWIDTH-1:0]    wr_old, wr_merged, rd_word;
  logic                 unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

  assign aw_hs  = awvalid_i && awready_q;
  assign w_hs   = wvalid_i && wready_q;
  assign ar_hs  = arvalid_i && arready_q;
  assign commit = aw_held_q && w_held_q;

  assign wr_idx      = word_index(32'(awaddr_q));
  assign rd_idx      = word_index(32'(araddr_i));
  assign wr_in_range = wr_idx < 32'(NUM_REG);
  assign rd_in_range = rd_idx < 32'(NUM_REG);

  // Out-of-range indices select nothing, so both words stay zero for them.
  always_comb begin
    wr_old  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (wr_idx == i) wr_old = regs_q[i];
      if (rd_idx == i) rd_word = regs_q[i];
    end
  end

  axi_lite_wstrb_merge #(
    .DWIDTH(DWIDTH)
  ) u_merge (
    .old_i   (wr_old),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .merged_o(wr_merged)
  );

  // AW and W are captured independently; a pending response blocks both.
  always_comb begin
    awready_d = awvalid_i && !awready_q && !aw_held_q && !bvalid_q;
    wready_d  = wvalid_i && !wready_q && !w_held_q && !bvalid_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
  end

  always_comb begin
    regs_d   = regs_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REG; i++) begin
        if (wr_in_range && wr_idx == i) regs_d[i] = wr_merged;
      end
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  // Read data is sampled on the AR handshake edge, ahead of any same-cycle commit.
  always_comb begin
    arready_d = arvalid_i && !arready_q && !rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_word : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge xrst_i) begin
    if (!xrst_i) begin
      awready_q <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      wready_q  <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
    end else begin
      awready_q <= awready_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      wready_q  <= wready_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign ctrl_o    = regs_q[0];

endmodule

// File: tb/tb_s_axi_lite_regfile.sv
// Directed self-checking bench for the AXI4-Lite register file.
module tb_s_axi_lite_regfile;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  s_axi_lite_regfile #(.DWIDTH(32), .REG_WIDTH(6), .NUM_REG(8)) dut (
    .clk_i(clk), .xrst_i(xrst),
    .awvalid_i(awvalid), .awaddr_i(awaddr), .awprot_i(awprot), .awready_o(awready),
    .wvalid_i(wvalid), .wdata_i(wdata), .wstrb_i(wstrb), .wready_o(wready),
    .bvalid_o(bvalid), .bresp_o(bresp), .bready_i(bready),
    .arvalid_i(arvalid), .araddr_i(araddr), .arprot_i(arprot), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .ctrl_o(ctrl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives AW and/or W until each handshake completes (bounded).
  task automatic do_aw_w(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input bit useAw, input bit useW, output bit ok);
    bit awPend, wPend, awSeen, wSeen;
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = useAw; wvalid = useW;
    awPend = useAw; wPend = useW; n = 0;
    while ((awPend || wPend) && n < 20) begin
      awSeen = awready; wSeen = wready;
      tick(); n++;
      if (awSeen && awPend) begin awvalid = 1'b0; awPend = 1'b0; end
      if (wSeen && wPend) begin wvalid = 1'b0; wPend = 1'b0; end
    end
    ok = !(awPend || wPend);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_b(output logic [1:0] resp, output bit ok);
    int n;
    bready = 1'b1; n = 0; resp = 2'b11;
    while (!bvalid && n < 20) begin tick(); n++; end
    ok = bvalid;
    if (ok) begin resp = bresp; tick(); end
    bready = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit ok);
    bit ok1, ok2;
    do_aw_w(addr, data, strb, 1'b1, 1'b1, ok1);
    resp = 2'b11; ok2 = 1'b0;
    if (ok1) do_b(resp, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output bit ok);
    bit arSeen;
    int n;
    araddr = addr; arvalid = 1'b1; ok = 1'b0; data = '0; resp = 2'b11; n = 0;
    while (n < 20) begin
      arSeen = arready;
      tick(); n++;
      if (arSeen) begin ok = 1'b1; break; end
    end
    arvalid = 1'b0;
    if (!ok) return;
    rready = 1'b1; n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    ok = rvalid;
    if (ok) begin data = rdata; resp = rresp; tick(); end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    repeat (3) tick();
    checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin errors++; $display("[TB] FAIL reset_valids got %b expected 00000", {awready, wready, arready, bvalid, rvalid}); end
    checks++; if ({bresp, rresp} !== 4'b0) begin errors++; $display("[TB] FAIL reset_resp got %b expected 0000", {bresp, rresp}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h expected 00000000", rdata); end
    checks++; if (ctrl !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl got %h expected 00000000", ctrl); end
    xrst = 1'b1;
    tick();
    checks++; if ({awready, wready, bvalid} !== 3'b0) begin errors++; $display("[TB] FAIL reset_idle got %b expected 000", {awready, wready, bvalid}); end
  endtask

  task automatic test_same_cycle_write();
    awaddr = 6'h00; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("[TB] FAIL same_ready got %b expected 11", {awready, wready}); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if ({awready, wready, bvalid} !== 3'b000) begin errors++; $display("[TB] FAIL same_after_hs got %b expected 000", {awready, wready, bvalid}); end
    tick();
    checks++; if (bvalid !== 1'b1) begin errors++; $display("[TB] FAIL same_bvalid got %b expected 1", bvalid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("[TB] FAIL same_bresp got %b expected 00", bresp); end
    checks++; if (ctrl !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL same_ctrl got %h expected deadbeef", ctrl); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL same_bdrop got %b expected 0", bvalid); end
  endtask

  task automatic test_w_before_aw();
    bit ok, sawB;
    logic [31:0] d;
    logic [1:0]  r;
    do_aw_w(6'h04, 32'h12345678, 4'hF, 1'b0, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wfirst_w_hs got timeout expected handshake"); end
    sawB = 1'b0;
    repeat (3) begin tick(); if (bvalid) sawB = 1'b1; end
    checks++; if (sawB !== 1'b0) begin errors++; $display("[TB] FAIL wfirst_early_b got %b expected 0", sawB); end
    awaddr = 6'h04; awvalid = 1'b1;
    tick();
    checks++; if ({awready, wready} !== 2'b10) begin errors++; $display("[TB] FAIL wfirst_awready got %b expected 10", {awready, wready}); end
    tick();
    awvalid = 1'b0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wfirst_b_commit got %b expected 0", bvalid); end
    tick();
    checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("[TB] FAIL wfirst_b got %b expected 100", {bvalid, bresp}); end
    bready = 1'b1; tick(); bready = 1'b0;
    do_read(6'h04, d, r, ok);
    checks++; if (!ok || d !== 32'h12345678 || r !== 2'b00) begin errors++; $display("[TB] FAIL wfirst_read got ok=%0d %h/%b expected 1 12345678/00", ok, d, r); end
    checks++; if (ctrl !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wfirst_ctrl got %h expected deadbeef", ctrl); end
  endtask

  task automatic test_wstrb();
    bit ok;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(6'h00, 32'h11223344, 4'b0101, r, ok);
    checks++; if (!ok || r !== 2'b00) begin errors++; $display("[TB] FAIL strb_bresp got ok=%0d %b expected 1 00", ok, r); end
    do_read(6'h00, d, r, ok);
    checks++; if (!ok || d !== 32'hDE22BE44 || r !== 2'b00) begin errors++; $display("[TB] FAIL strb_read got ok=%0d %h/%b expected 1 de22be44/00", ok, d, r); end
    checks++; if (ctrl !== 32'hDE22BE44) begin errors++; $display("[TB] FAIL strb_ctrl got %h expected de22be44", ctrl); end
  endtask

  task automatic test_out_of_range();
    bit ok;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(6'h20, 32'hFFFFFFFF, 4'hF, r, ok);
    checks++; if (!ok || r !== 2'b10) begin errors++; $display("[TB] FAIL oor_bresp got ok=%0d %b expected 1 10", ok, r); end
    do_read(6'h20, d, r, ok);
    checks++; if (!ok || d !== 32'h0 || r !== 2'b10) begin errors++; $display("[TB] FAIL oor_read got ok=%0d %h/%b expected 1 00000000/10", ok, d, r); end
    do_read(6'h3C, d, r, ok);
    checks++; if (!ok || d !== 32'h0 || r !== 2'b10) begin errors++; $display("[TB] FAIL oor_top got ok=%0d %h/%b expected 1 00000000/10", ok, d, r); end
    do_read(6'h00, d, r, ok);
    checks++; if (!ok || d !== 32'hDE22BE44 || r !== 2'b00) begin errors++; $display("[TB] FAIL oor_reg0 got ok=%0d %h/%b expected 1 de22be44/00", ok, d, r); end
    do_read(6'h06, d, r, ok);
    checks++; if (!ok || d !== 32'h12345678 || r !== 2'b00) begin errors++; $display("[TB] FAIL oor_misalign got ok=%0d %h/%b expected 1 12345678/00", ok, d, r); end
  endtask

  task automatic test_b_backpressure();
    bit ok, leak;
    logic [31:0] d;
    logic [1:0]  r;
    awaddr = 6'h08; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick(); tick();
    awaddr = 6'h0C; wdata = 32'h5A5A5A5A;
    tick();
    checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("[TB] FAIL bp_first_b got %b expected 100", {bvalid, bresp}); end
    leak = 1'b0;
    repeat (5) begin
      tick();
      if (!bvalid || awready || wready) leak = 1'b1;
    end
    checks++; if (leak !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold got %b expected 0", leak); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if ({bvalid, awready, wready} !== 3'b000) begin errors++; $display("[TB] FAIL bp_release got %b expected 000", {bvalid, awready, wready}); end
    tick();
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("[TB] FAIL bp_next_ready got %b expected 11", {awready, wready}); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    do_b(r, ok);
    checks++; if (!ok || r !== 2'b00) begin errors++; $display("[TB] FAIL bp_second_b got ok=%0d %b expected 1 00", ok, r); end
    do_read(6'h08, d, r, ok);
    checks++; if (!ok || d !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bp_read08 got ok=%0d %h expected 1 a5a5a5a5", ok, d); end
    do_read(6'h0C, d, r, ok);
    checks++; if (!ok || d !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL bp_read0c got ok=%0d %h expected 1 5a5a5a5a", ok, d); end
  endtask

  task automatic test_read_write_same();
    bit ok;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(6'h1C, 32'h0BADF00D, 4'hF, r, ok);
    checks++; if (!ok || r !== 2'b00) begin errors++; $display("[TB] FAIL rw_pre_write got ok=%0d %b expected 1 00", ok, r); end
    awaddr = 6'h1C; wdata = 32'h600DCAFE; wstrb = 4'hF; araddr = 6'h1C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; rready = 1'b0; bready = 1'b0;
    tick();
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("[TB] FAIL rw_ready got %b expected 111", {awready, wready, arready}); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rw_rdata got %b/%h expected 1/0badf00d", rvalid, rdata); end
    tick();
    checks++; if (bvalid !== 1'b1 || rdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rw_hold got %b/%h expected 1/0badf00d", bvalid, rdata); end
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    checks++; if ({rvalid, bvalid} !== 2'b00) begin errors++; $display("[TB] FAIL rw_drop got %b expected 00", {rvalid, bvalid}); end
    do_read(6'h1C, d, r, ok);
    checks++; if (!ok || d !== 32'h600DCAFE) begin errors++; $display("[TB] FAIL rw_after got ok=%0d %h expected 1 600dcafe", ok, d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [4] = '{32'h000000FF, 32'hFFFF0000, 32'h80000001, 32'h7FFFFFFE};
    logic [5:0]  adr [4] = '{6'h10, 6'h14, 6'h18, 6'h1C};
    bit ok;
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 4; i++) begin
      do_write(adr[i], pat[i], 4'hF, r, ok);
      checks++; if (!ok || r !== 2'b00) begin errors++; $display("[TB] FAIL b2b_bresp%0d got ok=%0d %b expected 1 00", i, ok, r); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(adr[i], d, r, ok);
      checks++; if (!ok || d !== pat[i] || r !== 2'b00) begin errors++; $display("[TB] FAIL b2b_read%0d got ok=%0d %h/%b expected 1 %h/00", i, ok, d, r, pat[i]); end
    end
    checks++; if (ctrl !== 32'hDE22BE44) begin errors++; $display("[TB] FAIL b2b_ctrl got %h expected de22be44", ctrl); end
  endtask

  task automatic test_reset_mid_write();
    bit ok, sawB;
    logic [31:0] d;
    logic [1:0]  r;
    do_aw_w(6'h18, 32'h0, 4'hF, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_aw_hs got timeout expected handshake"); end
    xrst = 1'b0;
    #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0 || ctrl !== 32'h0 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_outputs got %b ctrl=%h rdata=%h expected all 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, ctrl, rdata); end
    tick();
    xrst = 1'b1;
    tick();
    do_aw_w(6'h00, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, ok);
    sawB = 1'b0;
    repeat (3) begin tick(); if (bvalid) sawB = 1'b1; end
    checks++; if (!ok || sawB !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_stale got ok=%0d b=%b expected 1 0", ok, sawB); end
    do_aw_w(6'h18, 32'h0, 4'hF, 1'b1, 1'b0, ok);
    r = 2'b11;
    if (ok) do_b(r, ok);
    checks++; if (!ok || r !== 2'b00) begin errors++; $display("[TB] FAIL rst_new_write got ok=%0d %b expected 1 00", ok, r); end
    do_read(6'h18, d, r, ok);
    checks++; if (!ok || d !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rst_read18 got ok=%0d %h expected 1 cafef00d", ok, d); end
    do_read(6'h00, d, r, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("[TB] FAIL rst_read00 got ok=%0d %h expected 1 00000000", ok, d); end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_wstrb();
    test_out_of_range();
    test_b_backpressure();
    test_read_write_same();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
